// File: rtl/mag_avg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mag_avg_pkg
// Description : Shared types and width helpers for the multi-channel
//               magnitude averager.
// Revision    : 1.0 - initial release
// ============================================================================
package mag_avg_pkg;

    typedef enum logic {
        MODE_BLOCK = 1'b0,
        MODE_IIR   = 1'b1
    } mode_e;

    function automatic int acc_w(input int data_w, input int log2_len);
        return data_w + log2_len;
    endfunction

    function automatic int ch_w(input int channels);
        return (channels > 1) ? $clog2(channels) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mag_avg_multi_if.sv
`default_nettype none
// ============================================================================
// Module      : mag_avg_multi_if
// Description : Sample-in / result-out bundle of the multi-channel averager.
// Revision    : 1.0 - initial release
// ============================================================================
interface mag_avg_multi_if
    import mag_avg_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int CHANNELS = 2
);
    localparam int CH_W = ch_w(CHANNELS);

    logic [DATA_W-1:0] amplitude;
    logic [CH_W-1:0]   chan;
    logic              next;
    logic              clear;
    logic              mode;
    logic [DATA_W-1:0] average;
    logic [DATA_W-1:0] max_val;
    logic [CH_W-1:0]   avg_chan;
    logic              avg_valid;
    logic              chan_err;

    modport master (
        output amplitude, chan, next, clear, mode,
        input  average, max_val, avg_chan, avg_valid, chan_err
    );

    modport slave (
        input  amplitude, chan, next, clear, mode,
        output average, max_val, avg_chan, avg_valid, chan_err
    );

endinterface
`default_nettype wire

// File: rtl/mag_avg_lane.sv
`default_nettype none
// ============================================================================
// Module      : mag_avg_lane
// Description : Combinational per-sample update of one channel's accumulator,
//               counter and peak, plus block-result generation.
//               Define MAG_AVG_ROUND_EN for round-half-up results.
// Revision    : 1.0 - initial release
// ============================================================================
module mag_avg_lane
    import mag_avg_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int LOG2_LEN = 8,
    parameter int ACC_W    = acc_w(DATA_W, LOG2_LEN)
) (
    input  wire logic [ACC_W-1:0]    i_acc,
    input  wire logic [LOG2_LEN-1:0] i_cnt,
    input  wire logic [DATA_W-1:0]   i_peak,
    input  wire logic [DATA_W-1:0]   i_x,
    input  wire mode_e               i_mode,
    output logic      [ACC_W-1:0]    o_acc,
    output logic      [LOG2_LEN-1:0] o_cnt,
    output logic      [DATA_W-1:0]   o_peak,
    output logic      [DATA_W-1:0]   o_max,
    output logic      [DATA_W-1:0]   o_avg,
    output logic                     o_wrap
);

    // One guard bit: acc + x may briefly exceed ACC_W before the IIR leak term.
    logic [ACC_W:0] w_sum;
    logic [ACC_W:0] w_acc_new;
    logic [ACC_W:0] w_rnd;
    logic           w_unused_bits;

    assign w_sum     = {1'b0, i_acc} + (ACC_W+1)'(i_x);
    assign w_acc_new = (i_mode == MODE_IIR) ? (w_sum - (ACC_W+1)'(i_acc >> LOG2_LEN)) : w_sum;

`ifdef MAG_AVG_ROUND_EN
    localparam logic [ACC_W:0] c_HALF = {{ACC_W{1'b0}}, 1'b1} << (LOG2_LEN-1);
    assign w_rnd = w_acc_new + c_HALF;
`else
    assign w_rnd = w_acc_new;
`endif

    assign o_wrap = &i_cnt;
    assign o_cnt  = i_cnt + LOG2_LEN'(1);
    assign o_max  = (i_x > i_peak) ? i_x : i_peak;
    assign o_peak = o_wrap ? '0 : o_max;
    assign o_avg  = w_rnd[LOG2_LEN +: DATA_W];

    // IIR state carries over block boundaries; block mean restarts from zero.
    assign o_acc  = (o_wrap && i_mode == MODE_BLOCK) ? '0 : w_acc_new[ACC_W-1:0];

    assign w_unused_bits = ^{w_rnd[ACC_W], w_rnd[LOG2_LEN-1:0], w_acc_new[ACC_W]};

endmodule
`default_nettype wire

// File: rtl/mag_avg_multi.sv
`default_nettype none
// ============================================================================
// Module      : mag_avg_multi
// Description : Multi-channel block-mean / IIR magnitude averager with peak
//               hold. Define MAG_AVG_ROUND_EN for round-half-up results.
// Revision    : 1.0 - initial release
// ============================================================================
module mag_avg_multi
    import mag_avg_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int LOG2_LEN = 8,
    parameter int CHANNELS = 2
) (
    input  wire logic       clk,
    input  wire logic       rst,
    mag_avg_multi_if.slave  avg_if
);

    localparam int CH_W  = ch_w(CHANNELS);
    localparam int ACC_W = acc_w(DATA_W, LOG2_LEN);

    logic [ACC_W-1:0]    r_acc  [CHANNELS];
    logic [LOG2_LEN-1:0] r_cnt  [CHANNELS];
    logic [DATA_W-1:0]   r_peak [CHANNELS];
    mode_e               r_mode;

    logic [DATA_W-1:0]   r_average;
    logic [DATA_W-1:0]   r_max_val;
    logic [CH_W-1:0]     r_avg_chan;
    logic                r_avg_valid;
    logic                r_chan_err;

    logic [ACC_W-1:0]    w_acc_sel;
    logic [LOG2_LEN-1:0] w_cnt_sel;
    logic [DATA_W-1:0]   w_peak_sel;
    logic                w_legal;
    logic                w_take;
    logic [ACC_W-1:0]    w_acc_nxt;
    logic [LOG2_LEN-1:0] w_cnt_nxt;
    logic [DATA_W-1:0]   w_peak_nxt;
    logic [DATA_W-1:0]   w_max;
    logic [DATA_W-1:0]   w_avg;
    logic                w_wrap;

    // Channel mux; an out-of-range index matches nothing and reads as illegal.
    always_comb begin
        w_acc_sel  = '0;
        w_cnt_sel  = '0;
        w_peak_sel = '0;
        w_legal    = 1'b0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (avg_if.chan == CH_W'(i)) begin
                w_acc_sel  = r_acc[i];
                w_cnt_sel  = r_cnt[i];
                w_peak_sel = r_peak[i];
                w_legal    = 1'b1;
            end
        end
    end

    assign w_take = avg_if.next && !avg_if.clear && w_legal;

    mag_avg_lane #(
        .DATA_W   (DATA_W),
        .LOG2_LEN (LOG2_LEN),
        .ACC_W    (ACC_W)
    ) u_lane (
        .i_acc  (w_acc_sel),
        .i_cnt  (w_cnt_sel),
        .i_peak (w_peak_sel),
        .i_x    (avg_if.amplitude),
        .i_mode (r_mode),
        .o_acc  (w_acc_nxt),
        .o_cnt  (w_cnt_nxt),
        .o_peak (w_peak_nxt),
        .o_max  (w_max),
        .o_avg  (w_avg),
        .o_wrap (w_wrap)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_mode <= MODE_BLOCK;
            for (int i = 0; i < CHANNELS; i++) begin
                r_acc[i]  <= '0;
                r_cnt[i]  <= '0;
                r_peak[i] <= '0;
            end
        end else if (avg_if.clear) begin
            r_mode <= mode_e'(avg_if.mode);
            for (int i = 0; i < CHANNELS; i++) begin
                r_acc[i]  <= '0;
                r_cnt[i]  <= '0;
                r_peak[i] <= '0;
            end
        end else if (w_take) begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (avg_if.chan == CH_W'(i)) begin
                    r_acc[i]  <= w_acc_nxt;
                    r_cnt[i]  <= w_cnt_nxt;
                    r_peak[i] <= w_peak_nxt;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_average   <= '0;
            r_max_val   <= '0;
            r_avg_chan  <= '0;
            r_avg_valid <= 1'b0;
            r_chan_err  <= 1'b0;
        end else begin
            r_avg_valid <= w_take && w_wrap;
            r_chan_err  <= avg_if.next && !w_legal;
            if (w_take && w_wrap) begin
                r_average  <= w_avg;
                r_max_val  <= w_max;
                r_avg_chan <= avg_if.chan;
            end
        end
    end

    assign avg_if.average   = r_average;
    assign avg_if.max_val   = r_max_val;
    assign avg_if.avg_chan  = r_avg_chan;
    assign avg_if.avg_valid = r_avg_valid;
    assign avg_if.chan_err  = r_chan_err;

endmodule
`default_nettype wire

// File: tb/tb_mag_avg_multi.sv
`default_nettype none
// ============================================================================
// Module      : tb_mag_avg_multi
// Description : Self-checking bench for mag_avg_multi (LOG2_LEN=3, 3 channels).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mag_avg_multi;
    import mag_avg_pkg::*;

    localparam int DATA_W   = 16;
    localparam int LOG2_LEN = 3;
    localparam int CHANNELS = 3;
    localparam int CH_W     = ch_w(CHANNELS);
    localparam int BLK      = 1 << LOG2_LEN;
`ifdef MAG_AVG_ROUND_EN
    localparam int RND = 1;
`else
    localparam int RND = 0;
`endif

    typedef struct {
        bit n;
        int ch;
        int amp;
        bit clr;
        bit md;
        bit ev;
        int ea;
        int em;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    mag_avg_multi_if #(.DATA_W(DATA_W), .CHANNELS(CHANNELS)) bus ();

    mag_avg_multi #(
        .DATA_W   (DATA_W),
        .LOG2_LEN (LOG2_LEN),
        .CHANNELS (CHANNELS)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .avg_if (bus)
    );

    int n_checks = 0;
    int n_err    = 0;

    // Reference state: raw samples of the open block per channel, IIR accumulators.
    int     mq   [CHANNELS][$];
    longint miir [CHANNELS];
    bit     mmode;
    bit     exp_valid, exp_err;
    longint exp_avg, exp_max, exp_ch;

    vec_t tbl[$];

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < CHANNELS; c++) begin
            mq[c].delete();
            miir[c] = 0;
        end
        mmode = 1'b0;
        exp_valid = 0; exp_err = 0; exp_avg = 0; exp_max = 0; exp_ch = 0;
    endtask

    task automatic model_apply(input bit n, input int ch, input int amp, input bit clr, input bit md);
        longint tot;
        longint res;
        int     pk;
        exp_valid = 0;
        exp_err   = n && (ch >= CHANNELS);
        if (clr) begin
            for (int c = 0; c < CHANNELS; c++) begin
                mq[c].delete();
                miir[c] = 0;
            end
            mmode = md;
        end else if (n && ch < CHANNELS) begin
            mq[ch].push_back(amp);
            if (mmode) miir[ch] = miir[ch] + amp - (miir[ch] >> LOG2_LEN);
            if (mq[ch].size() == BLK) begin
                tot = 0; pk = 0;
                for (int k = 0; k < BLK; k++) begin
                    tot += mq[ch][k];
                    if (mq[ch][k] > pk) pk = mq[ch][k];
                end
                res       = mmode ? miir[ch] : tot;
                exp_avg   = (res + RND * (BLK / 2)) / BLK;
                exp_max   = pk;
                exp_ch    = ch;
                exp_valid = 1;
                mq[ch].delete();
            end
        end
    endtask

    task automatic step(input bit n, input int ch, input int amp, input bit clr, input bit md);
        @(negedge clk);
        bus.next      = n;
        bus.chan      = CH_W'(ch);
        bus.amplitude = DATA_W'(amp);
        bus.clear     = clr;
        bus.mode      = md;
        model_apply(n, ch, amp, clr, md);
        @(posedge clk);
        #1;
        chk("avg_valid", bus.avg_valid, exp_valid);
        chk("chan_err",  bus.chan_err,  exp_err);
        chk("average",   bus.average,   exp_avg);
        chk("max_val",   bus.max_val,   exp_max);
        chk("avg_chan",  bus.avg_chan,  exp_ch);
    endtask

    task automatic check_zero_outputs(input string tag);
        chk({tag, "_average"},   bus.average,   0);
        chk({tag, "_max_val"},   bus.max_val,   0);
        chk({tag, "_avg_chan"},  bus.avg_chan,  0);
        chk({tag, "_avg_valid"}, bus.avg_valid, 0);
        chk({tag, "_chan_err"},  bus.chan_err,  0);
    endtask

    task automatic add(input bit n, input int ch, input int amp, input bit clr, input bit md,
                       input bit ev, input int ea, input int em);
        vec_t v;
        v.n = n; v.ch = ch; v.amp = amp; v.clr = clr; v.md = md;
        v.ev = ev; v.ea = ea; v.em = em;
        tbl.push_back(v);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int pulses;
        int d;
        bus.next = 0; bus.chan = '0; bus.amplitude = '0; bus.clear = 0; bus.mode = 0;
        model_reset();
        #22;
        check_zero_outputs("reset");
        @(negedge clk);
        rst = 1'b1;

        // Directed vectors: block mean, peak reload, rounding, clear-vs-next.
        add(0, 0, 0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 2; i++) add(1, 0, 1080, 0, 0, 0, 0, 0);
        for (int i = 0; i < 6; i++) add(1, 0, 1900, 0, 0, i == 5, 1695, 1900);
        for (int i = 0; i < 8; i++) add(1, 0, 1960, 0, 0, i == 7, 1960, 1960);
        for (int i = 0; i < 4; i++) add(1, 0, 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) add(1, 0, 0, 0, 0, i == 3, RND, 1);
        for (int i = 0; i < 3; i++) add(1, 0, 500, 0, 0, 0, 0, 0);
        add(1, 0, 5000, 1, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) add(1, 0, 300, 0, 0, i == 7, 300, 300);

        foreach (tbl[i]) begin
            step(tbl[i].n, tbl[i].ch, tbl[i].amp, tbl[i].clr, tbl[i].md);
            chk("tbl_valid", bus.avg_valid, tbl[i].ev);
            if (tbl[i].ev) begin
                chk("tbl_average", bus.average, tbl[i].ea);
                chk("tbl_max_val", bus.max_val, tbl[i].em);
            end
        end

        // IIR: converges from below and settles within one LSB of the input.
        step(0, 0, 0, 1, 1);
        for (int b = 0; b < 12; b++) begin
            for (int s = 0; s < BLK; s++) step(1, 0, 1900, 0, 0);
            if (b == 0) chk("iir_first_below", bus.average < 1900, 1);
        end
        d = int'(bus.average) - 1900;
        chk("iir_converged", (d <= 1 && d >= -1), 1);

        // Interleaved channels at full rate: adjacent completions.
        step(0, 0, 0, 1, 0);
        pulses = 0;
        for (int i = 0; i < BLK; i++) begin
            step(1, 0, 1080, 0, 0);
            pulses += bus.avg_valid;
            step(1, 1, 1960, 0, 0);
            pulses += bus.avg_valid;
        end
        chk("interleave_pulses", pulses, 2);
        step(0, 0, 0, 0, 0);

        // Illegal channel in the middle of a block leaves state untouched.
        for (int i = 0; i < 4; i++) step(1, 2, 100 * (i + 1), 0, 0);
        step(1, 3, 9999, 0, 0);
        chk("chan_err_pulse", bus.chan_err, 1);
        for (int i = 0; i < 4; i++) step(1, 2, 50, 0, 0);
        chk("chan_err_block_avg", bus.average, (100 + 200 + 300 + 400 + 200 + RND * 4) / 8);
        chk("chan_err_block_max", bus.max_val, 400);

        // Asynchronous reset mid-block, then a fresh block counted from zero.
        for (int i = 0; i < 3; i++) step(1, 0, 4000, 0, 0);
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        model_reset();
        check_zero_outputs("midrst");
        @(negedge clk);
        bus.next = 0; bus.clear = 0;
        rst = 1'b1;
        for (int i = 0; i < BLK; i++) step(1, 0, 700, 0, 0);
        chk("post_rst_valid", bus.avg_valid, 1);
        chk("post_rst_avg", bus.average, 700);

        // Randomized traffic including illegal channels, gaps, clears and mode flips.
        step(0, 0, 0, 1, 0);
        for (int i = 0; i < 1500; i++) begin
            step($urandom_range(0, 9) < 8,
                 int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 65535)),
                 $urandom_range(0, 199) == 0,
                 $urandom_range(0, 1) == 1);
        end
        step(0, 0, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
`default_nettype wire
